// File: rtl/dogx_pkg.sv
// dogx_pkg: shared CIC types, width helper and default output width
package dogx_pkg;
    localparam int OUT_W_DEF = 16;

    typedef enum logic [1:0] {IDLE, COMB, ROUND, OUT} cic_state_t;

    function automatic int cic_acc_w(input int in_w, input int order, input int dec_log2);
        return in_w + order * dec_log2;
    endfunction
endpackage

// File: rtl/dogx_cic_integrator_chain.sv
// dogx_cic_integrator_chain: ORDER-stage modular integrator cascade, one register per stage
module dogx_cic_integrator_chain #(
    parameter int ORDER = 4,
    parameter int ACC_W = 35
) (
    input  logic               CLK_24M,
    input  logic               reset,
    input  logic               sample_en,
    input  logic [ACC_W-1:0]   data_ext,
    output logic [ACC_W-1:0]   last_next
);
    logic [ACC_W-1:0] integ [ORDER];
    logic [ACC_W-1:0] nxt   [ORDER];

    genvar g;
    generate
        for (g = 0; g < ORDER; g++) begin : g_stage
            if (g == 0) begin : g_first
                assign nxt[g] = integ[g] + data_ext;
            end else begin : g_next
                assign nxt[g] = integ[g] + integ[g-1];
            end
        end
    endgenerate

    assign last_next = nxt[ORDER-1];

    // every stage advances together on each input strobe, using the previous values of its feeder
    always_ff @(posedge CLK_24M) begin
        if (!reset) begin
            for (int k = 0; k < ORDER; k++) integ[k] <= '0;
        end else if (sample_en) begin
            integ <= nxt;
        end
    end
endmodule

// File: rtl/dogx_cic_decimator.sv
// dogx_cic_decimator: CIC decimator with time-multiplexed combs; optional alpha tag via DOGX_CIC_ALPHA_TAG_EN
module dogx_cic_decimator import dogx_pkg::*; #(
    parameter int IN_W     = 11,
    parameter int ORDER    = 4,
    parameter int DEC_LOG2 = 6,
    parameter int OUT_W    = OUT_W_DEF
) (
    input  logic             CLK_24M,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [IN_W-1:0]  data_in,
    input  logic             alpha_in,
    output logic [OUT_W-1:0] data_out,
    output logic             data_valid,
    output logic             alpha_out,
    output logic             alpha_mixed,
    output logic             overrun
);
    localparam int ACC_W = cic_acc_w(IN_W, ORDER, DEC_LOG2);
    localparam int S = ACC_W - OUT_W;
    localparam logic [2:0] LAST = 3'(ORDER - 1);

    cic_state_t state;
    logic [DEC_LOG2-1:0] sample_cnt;
    logic [2:0] stg;
    logic dec;
    logic signed [ACC_W-1:0] data_ext, last_next, snap, y, y_prev, diff;
    logic signed [ACC_W-1:0] dly [ORDER];
    logic signed [OUT_W-1:0] r_sat, r_q;

    assign data_ext = ACC_W'($signed(data_in));
    assign dec = sample_en && (&sample_cnt);
    assign y_prev = (stg == 3'd0) ? snap : y;
    assign diff = y_prev - dly[0];

    dogx_cic_integrator_chain #(.ORDER(ORDER), .ACC_W(ACC_W)) u_integ (
        .CLK_24M   (CLK_24M),
        .reset     (reset),
        .sample_en (sample_en),
        .data_ext  (data_ext),
        .last_next (last_next)
    );

    generate
        if (S > 0) begin : g_shr
            localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (S - 1);
            localparam logic signed [ACC_W:0] HI = {{(S+2){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [ACC_W:0] LO = ~HI;
            logic signed [ACC_W:0] sh;
            assign sh = ($signed({y[ACC_W-1], y}) + $signed(HALF)) >>> S;
            assign r_sat = sh > HI ? OUT_W'(HI) : sh < LO ? OUT_W'(LO) : OUT_W'(sh);
        end else begin : g_shl
            assign r_sat = OUT_W'(y) <<< (-S);
        end
    endgenerate

    // sample counter plus the IDLE -> COMB x ORDER -> ROUND -> OUT sequencer; the comb delays rotate so stage k always reads dly[0]
    always_ff @(posedge CLK_24M) begin
        if (!reset) begin
            state      <= IDLE;
            sample_cnt <= '0;
            stg        <= '0;
            snap       <= '0;
            y          <= '0;
            r_q        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            for (int k = 0; k < ORDER; k++) dly[k] <= '0;
        end else begin
            data_valid <= 1'b0;
            if (sample_en) sample_cnt <= sample_cnt + 1'b1;
            if (dec && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (dec) begin
                        snap  <= last_next;
                        stg   <= '0;
                        state <= COMB;
                    end
                end
                COMB: begin
                    y <= diff;
                    for (int k = 0; k < ORDER - 1; k++) dly[k] <= dly[k+1];
                    dly[ORDER-1] <= y_prev;
                    stg <= stg + 3'd1;
                    if (stg == LAST) state <= ROUND;
                end
                ROUND: begin
                    r_q   <= r_sat;
                    state <= OUT;
                end
                default: begin
                    data_out   <= r_q;
                    data_valid <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef DOGX_CIC_ALPHA_TAG_EN
    logic alpha_prev, alpha_flag, alpha_last, alpha_win;

    // track alpha changes inside a window, latch them at the decimation instant and publish with the sample
    always_ff @(posedge CLK_24M) begin
        if (!reset) begin
            alpha_prev  <= 1'b0;
            alpha_flag  <= 1'b0;
            alpha_last  <= 1'b0;
            alpha_win   <= 1'b0;
            alpha_out   <= 1'b0;
            alpha_mixed <= 1'b0;
        end else begin
            if (sample_en) alpha_prev <= alpha_in;
            if (dec) alpha_flag <= 1'b0;
            else if (sample_en && |sample_cnt) alpha_flag <= alpha_flag | (alpha_in ^ alpha_prev);
            if (dec && state == IDLE) begin
                alpha_last <= alpha_in;
                alpha_win  <= alpha_flag | (alpha_in ^ alpha_prev);
            end
            if (state == OUT) begin
                alpha_out   <= alpha_last;
                alpha_mixed <= alpha_win;
            end
        end
    end
`else
    logic alpha_unused;
    assign alpha_unused = alpha_in;
    assign alpha_out    = 1'b0;
    assign alpha_mixed  = 1'b0;
`endif
endmodule

// File: tb/tb_dogx_cic_decimator.sv
// tb_dogx_cic_decimator: scoreboard bench for dogx_cic_decimator (default and DEC_LOG2=1 instances)
module tb_dogx_cic_decimator;
    logic CLK_24M = 1'b0;
    always #5 CLK_24M = ~CLK_24M;

    logic        reset = 1'b0, sample_en = 1'b0, alpha_in = 1'b0;
    logic [10:0] data_in = '0;
    logic [15:0] data_out;
    logic        data_valid, alpha_out, alpha_mixed, overrun;

    logic        reset_b = 1'b0, sample_en_b = 1'b0, alpha_in_b = 1'b0;
    logic [10:0] data_in_b = '0;
    logic [15:0] data_out_b;
    logic        data_valid_b, alpha_out_b, alpha_mixed_b, overrun_b;

    dogx_cic_decimator dut (
        .CLK_24M(CLK_24M), .reset(reset), .sample_en(sample_en), .data_in(data_in),
        .alpha_in(alpha_in), .data_out(data_out), .data_valid(data_valid),
        .alpha_out(alpha_out), .alpha_mixed(alpha_mixed), .overrun(overrun)
    );

    dogx_cic_decimator #(.DEC_LOG2(1)) dut_b (
        .CLK_24M(CLK_24M), .reset(reset_b), .sample_en(sample_en_b), .data_in(data_in_b),
        .alpha_in(alpha_in_b), .data_out(data_out_b), .data_valid(data_valid_b),
        .alpha_out(alpha_out_b), .alpha_mixed(alpha_mixed_b), .overrun(overrun_b)
    );

    typedef struct {
        bit          chk;
        logic [15:0] v;
        logic        ao;
        logic        am;
    } exp_t;

    exp_t sb[$];
    int   vcyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t got;

    always @(posedge CLK_24M) cyc <= cyc + 1;

    always @(negedge CLK_24M) begin
        if (data_valid === 1'b1) begin
            vcyc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid data_out=%0d expected no output", $signed(data_out));
            end else begin
                got = sb.pop_front();
                if (got.chk) begin
                    checks++;
                    if (data_out !== got.v) begin
                        errors++;
                        $display("FAIL data_out got=%0d exp=%0d", $signed(data_out), $signed(got.v));
                    end
                end
                checks++;
                if (alpha_out !== got.ao || alpha_mixed !== got.am) begin
                    errors++;
                    $display("FAIL alpha_tag got=%b%b exp=%b%b", alpha_out, alpha_mixed, got.ao, got.am);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK_24M);
        reset = 1'b0;
        sample_en = 1'b0;
        repeat (2) @(negedge CLK_24M);
        reset = 1'b1;
        sb.delete();
        vcyc.delete();
    endtask

    task automatic run_samples(input int n, input int x, input int chk_from, input int a_tog);
        for (int s = 0; s < n; s++) begin
            @(negedge CLK_24M);
            sample_en = 1'b1;
            data_in = 11'(x);
            alpha_in = (s >= a_tog);
            if (s % 64 == 63) begin
                exp_t e;
                int w;
                w = s / 64;
                e.chk = (w >= chk_from);
                e.v = 16'(x * 32);
`ifdef DOGX_CIC_ALPHA_TAG_EN
                e.ao = alpha_in;
                e.am = (a_tog > w * 64 && a_tog <= w * 64 + 63);
`else
                e.ao = 1'b0;
                e.am = 1'b0;
`endif
                sb.push_back(e);
            end
            @(negedge CLK_24M);
            sample_en = 1'b0;
            repeat (6) @(negedge CLK_24M);
        end
    endtask

    task automatic test_reset();
        @(negedge CLK_24M);
        reset = 1'b0;
        repeat (3) @(negedge CLK_24M);
        checks += 5;
        if (data_out !== 16'd0) begin errors++; $display("FAIL reset_data_out got=%0d exp=0", data_out); end
        if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        if (alpha_out !== 1'b0) begin errors++; $display("FAIL reset_alpha_out got=%b exp=0", alpha_out); end
        if (alpha_mixed !== 1'b0) begin errors++; $display("FAIL reset_alpha_mixed got=%b exp=0", alpha_mixed); end
        reset = 1'b1;
    endtask

    task automatic test_constant(input int x);
        do_reset();
        run_samples(8 * 64, x, 4, 1 << 30);
        repeat (12) @(negedge CLK_24M);
        checks += 3;
        if (sb.size() != 0) begin errors++; $display("FAIL const_drain x=%0d pending=%0d exp=0", x, sb.size()); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL const_overrun x=%0d got=%b exp=0", x, overrun); end
        if (vcyc.size() != 8) begin errors++; $display("FAIL const_count x=%0d got=%0d exp=8", x, vcyc.size()); end
        for (int i = 1; i < vcyc.size(); i++) begin
            checks++;
            if (vcyc[i] - vcyc[i-1] != 512) begin
                errors++;
                $display("FAIL const_interval x=%0d got=%0d exp=512", x, vcyc[i] - vcyc[i-1]);
            end
        end
    endtask

    task automatic test_latency();
        do_reset();
        run_samples(63, 50, 99, 1 << 30);
        @(negedge CLK_24M);
        sample_en = 1'b1;
        data_in = 11'd50;
        alpha_in = 1'b0;
        sb.push_back('{chk: 1'b0, v: 16'd0, ao: 1'b0, am: 1'b0});
        @(posedge CLK_24M);
        #1 sample_en = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge CLK_24M);
            #1;
            checks++;
            if (data_valid !== 1'(k == 6)) begin
                errors++;
                $display("FAIL latency_valid edge=t+%0d got=%b exp=%b", k, data_valid, k == 6);
            end
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL latency_drain pending=%0d exp=0", sb.size()); end
    endtask

    task automatic test_reset_mid_comb();
        bit seen;
        do_reset();
        run_samples(5 * 64 + 63, 100, 4, 1 << 30);
        @(negedge CLK_24M);
        sample_en = 1'b1;
        @(posedge CLK_24M);
        #1 sample_en = 1'b0;
        @(posedge CLK_24M);
        #1;
        checks++;
        if (data_out !== 16'd3200) begin errors++; $display("FAIL midreset_hold got=%0d exp=3200", $signed(data_out)); end
        reset = 1'b0;
        @(posedge CLK_24M);
        #1 reset = 1'b1;
        checks += 4;
        if (data_out !== 16'd0) begin errors++; $display("FAIL midreset_data_out got=%0d exp=0", data_out); end
        if (data_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b exp=0", data_valid); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL midreset_overrun got=%b exp=0", overrun); end
        if (alpha_out !== 1'b0 || alpha_mixed !== 1'b0) begin errors++; $display("FAIL midreset_alpha got=%b%b exp=00", alpha_out, alpha_mixed); end
        seen = 1'b0;
        repeat (20) begin
            @(posedge CLK_24M);
            #1 if (data_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midreset_aborted_valid got=1 exp=0"); end
        vcyc.delete();
        run_samples(64, 100, 99, 1 << 30);
        repeat (12) @(negedge CLK_24M);
        checks += 2;
        if (vcyc.size() != 1) begin errors++; $display("FAIL midreset_first_out count=%0d exp=1", vcyc.size()); end
        if (sb.size() != 0) begin errors++; $display("FAIL midreset_drain pending=%0d exp=0", sb.size()); end
    endtask

    task automatic test_overrun();
        bit dropped;
        @(posedge CLK_24M);
        #1 reset_b = 1'b1;
        sample_en_b = 1'b1;
        data_in_b = 11'd5;
        @(posedge CLK_24M);
        #1 checks++;
        if (overrun_b !== 1'b0) begin errors++; $display("FAIL overrun_e1 got=%b exp=0", overrun_b); end
        @(posedge CLK_24M);
        #1 checks++;
        if (overrun_b !== 1'b0) begin errors++; $display("FAIL overrun_first_dec got=%b exp=0", overrun_b); end
        @(posedge CLK_24M);
        @(posedge CLK_24M);
        #1 checks++;
        if (overrun_b !== 1'b1) begin errors++; $display("FAIL overrun_second_dec got=%b exp=1", overrun_b); end
        dropped = 1'b0;
        repeat (40) begin
            @(posedge CLK_24M);
            #1 if (overrun_b !== 1'b1) dropped = 1'b1;
        end
        checks++;
        if (dropped) begin errors++; $display("FAIL overrun_sticky got=0 exp=1"); end
        reset_b = 1'b0;
        sample_en_b = 1'b0;
        @(posedge CLK_24M);
        #1 checks++;
        if (overrun_b !== 1'b0) begin errors++; $display("FAIL overrun_reset got=%b exp=0", overrun_b); end
        reset_b = 1'b1;
    endtask

    task automatic test_alpha();
        logic ao_exp;
        do_reset();
        run_samples(3 * 64, 200, 4, 94);
        repeat (12) @(negedge CLK_24M);
`ifdef DOGX_CIC_ALPHA_TAG_EN
        ao_exp = 1'b1;
`else
        ao_exp = 1'b0;
`endif
        checks += 2;
        if (sb.size() != 0) begin errors++; $display("FAIL alpha_drain pending=%0d exp=0", sb.size()); end
        if (alpha_out !== ao_exp || alpha_mixed !== 1'b0) begin
            errors++;
            $display("FAIL alpha_final got=%b%b exp=%b0", alpha_out, alpha_mixed, ao_exp);
        end
    endtask

    initial begin
        test_reset();
        test_constant(100);
        test_constant(-1024);
        test_constant(1023);
        test_constant(-300);
        test_constant(int'($urandom_range(0, 2047)) - 1024);
        test_latency();
        test_reset_mid_comb();
        test_overrun();
        test_alpha();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
